mma_result_drain: RTL and testbench

Downstream stage of the FP16/FP32 tensor-core MMA tile. Captures the full FP32 result tile (matrix D, M×N, row-major) when the tile pulses its one-cycle result-valid strobe. Streams the elements out one per handshake on a valid/ready port, optionally rounding each to IEEE FP16. Frees the tile so it can start its next MMA while the previous result drains; its busy flag is used to gate the tile's MMA enable.

---
 rtl/mma_result_drain.sv | 137 +++++++++++++
 tb/tb_mma_result_drain.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mma_result_drain.sv
// Drains a captured MMA result tile as a valid/ready element stream, optionally rounding
// each FP32 element to FP16 (RNE), so the tile is free to start its next MMA.
module mma_result_drain #(
    parameter int unsigned M        = 4,
    parameter int unsigned N        = 4,
    parameter int unsigned C_ELEMS  = M * N,
    parameter bit          OUT_FP16 = 1'b1,
    parameter int unsigned IDX_W    = $clog2(C_ELEMS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             result_valid,
    input  logic [31:0]      matrix_d [0:C_ELEMS-1],
    output logic             drain_busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             drop_err,
    input  logic             err_clear
);

    typedef enum logic {StIdle, StStream} state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [31:0]       tile_q [0:C_ELEMS-1];
    logic [31:0]       tile_d [0:C_ELEMS-1];
    logic              drop_q, drop_d;
    logic              capture;
    logic              drop_set;
    logic              stream;
    logic              is_last;
    logic [31:0]       cur_elem;

    function automatic logic [15:0] fp32_to_fp16(input logic [31:0] x);
        logic        s;
        logic [7:0]  e;
        logic [22:0] f;
        logic [4:0]  exp5;
        logic [4:0]  sh;
        logic [47:0] shifted;
        logic        rnd;
        logic [14:0] mag;
        s = x[31];
        e = x[30:23];
        f = x[22:0];
        // Only used inside their ranges below, where the mod-32 arithmetic is exact:
        // exp5 = e - 112 for e in 113..142, sh = 126 - e for e in 102..112.
        exp5    = e[4:0] - 5'd16;
        sh      = 5'd30 - e[4:0];
        shifted = {1'b1, f, 24'h0} >> sh;
        rnd     = 1'b0;
        mag     = '0;
        if (e == 8'hff) begin
            mag = (f != '0) ? 15'h7e00 : 15'h7c00;
        end else if (e >= 8'd143) begin
            mag = 15'h7c00;
        end else if (e >= 8'd113) begin
            // A carry out of the fraction bumps the exponent; from 0x7BFF it lands on Inf.
            rnd = f[12] & ((|f[11:0]) | f[13]);
            mag = {exp5, f[22:13]} + 15'(rnd);
        end else if (e >= 8'd102) begin
            rnd = shifted[23] & ((|shifted[22:0]) | shifted[24]);
            mag = 15'(shifted[47:24]) + 15'(rnd);
        end
        return {s, mag};
    endfunction

    assign stream   = (state_q == StStream);
    assign is_last  = (idx_q == IDX_W'(C_ELEMS - 1));
    assign cur_elem = tile_q[idx_q];

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        tile_d   = tile_q;
        capture  = 1'b0;
        drop_set = 1'b0;
        unique case (state_q)
            StIdle: begin
                capture = result_valid;
            end
            StStream: begin
                if (out_ready) begin
                    if (is_last) begin
                        state_d = StIdle;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                // Only the final handshake frees the buffer for a new tile in the same cycle.
                if (result_valid) begin
                    if (out_ready && is_last) begin
                        capture = 1'b1;
                    end else begin
                        drop_set = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        if (capture) begin
            tile_d  = matrix_d;
            idx_d   = '0;
            state_d = StStream;
        end
        drop_d = drop_set | (drop_q & ~err_clear);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            drop_q  <= 1'b0;
            tile_q  <= '{default: '0};
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            drop_q  <= drop_d;
            tile_q  <= tile_d;
        end
    end

    assign out_valid  = stream;
    assign drain_busy = stream;
    assign out_idx    = idx_q;
    assign out_last   = stream & is_last;
    assign drop_err   = drop_q;
    assign out_data   = !stream ? '0 :
                        OUT_FP16 ? {16'h0, fp32_to_fp16(cur_elem)} : cur_elem;

endmodule

// File: tb/tb_mma_result_drain.sv
// Randomized scoreboard bench: an FP16 and an FP32 instance share stimulus; expected elements
// come from a queue-based drain model and an arithmetic RNE reference conversion.
module tb_mma_result_drain;

    localparam int CE = 16;

    typedef struct {
        int          idx;
        logic        last;
        logic [15:0] d16;
        logic [31:0] d32;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        result_valid;
    logic        out_ready;
    logic        err_clear;
    logic [31:0] tile_in [0:CE-1];

    logic        h_busy, h_valid, h_last, h_drop;
    logic [31:0] h_data;
    logic [3:0]  h_idx;
    logic        w_busy, w_valid, w_last, w_drop;
    logic [31:0] w_data;
    logic [3:0]  w_idx;

    exp_t exp_q [$];
    exp_t stage_q [$];
    logic drop_now;
    logic drop_next;
    int   errors;
    int   checks;

    mma_result_drain #(.OUT_FP16(1'b1)) dut16 (
        .clk(clk), .rst_n(rst_n), .result_valid(result_valid), .matrix_d(tile_in),
        .drain_busy(h_busy), .out_valid(h_valid), .out_ready(out_ready), .out_data(h_data),
        .out_idx(h_idx), .out_last(h_last), .drop_err(h_drop), .err_clear(err_clear)
    );

    mma_result_drain #(.OUT_FP16(1'b0)) dut32 (
        .clk(clk), .rst_n(rst_n), .result_valid(result_valid), .matrix_d(tile_in),
        .drain_busy(w_busy), .out_valid(w_valid), .out_ready(out_ready), .out_data(w_data),
        .out_idx(w_idx), .out_last(w_last), .drop_err(w_drop), .err_clear(err_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Value-level reference: scale the 24-bit significand to the FP16 quantum and round.
    function automatic logic [15:0] ref_fp16(input logic [31:0] x);
        logic   s;
        int     e;
        int     ue;
        int     k;
        longint f;
        longint sig;
        longint q;
        longint r;
        longint half;
        s = x[31];
        e = int'(x[30:23]);
        f = longint'(x[22:0]);
        if (e == 255) return (f != 0) ? {s, 15'h7e00} : {s, 15'h7c00};
        if (e == 0) return {s, 15'h0};
        sig = f + (longint'(1) << 23);
        ue  = e - 127;
        k   = (ue >= -14) ? 13 : (-1 - ue);
        if (k > 40) return {s, 15'h0};
        q    = sig >> k;
        r    = sig - (q << k);
        half = longint'(1) << (k - 1);
        if (r > half || (r == half && q[0])) q = q + 1;
        if (ue >= -14) begin
            if (q == 2048) begin
                q  = 1024;
                ue = ue + 1;
            end
            if (ue > 15) return {s, 15'h7c00};
            return {s, 5'(ue + 15), 10'(q - 1024)};
        end
        return {s, 15'(q)};
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        case ($urandom % 8)
            0, 1, 2, 3, 4: w[30:23] = 8'($urandom_range(145, 97));
            5:             w[30:23] = ($urandom % 2 == 0) ? 8'h00 : 8'hff;
            6: begin
                w[30:23] = 8'($urandom_range(114, 100));
                w[12:0]  = 13'h1000;
            end
            default: ;
        endcase
        return w;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic bound_ok(input bit ok, input string name);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: wait bound expired at %0t", name, $time);
        end
    endtask

    task automatic sync();
        @(negedge clk);
    endtask

    // Drive one cycle of inputs and advance the drain model to the coming edge.
    task automatic drive(input bit v, input bit r, input bit c, input int nfix,
                         input logic [31:0] t0, input logic [31:0] t1);
        bit   acc;
        exp_t x;
        result_valid = v;
        out_ready    = r;
        err_clear    = c;
        if (v) begin
            for (int i = 0; i < CE; i++) tile_in[i] = rand_word();
            if (nfix > 0) tile_in[0] = t0;
            if (nfix > 1) tile_in[1] = t1;
        end
        acc = v && (exp_q.size() == 0 || (exp_q.size() == 1 && r));
        if (acc) begin
            for (int i = 0; i < CE; i++) begin
                x.idx  = i;
                x.last = (i == CE - 1);
                x.d16  = ref_fp16(tile_in[i]);
                x.d32  = tile_in[i];
                stage_q.push_back(x);
            end
        end
        drop_next = (v && !acc) ? 1'b1 : (c ? 1'b0 : drop_now);
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) begin
            sync();
            drive(1'b0, r, 1'b0, 0, 32'h0, 32'h0);
        end
    endtask

    task automatic drain_all();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            if (exp_q.size() == 0 && stage_q.size() == 0) begin
                done = 1'b1;
            end else begin
                sync();
                drive(1'b0, 1'b1, 1'b0, 0, 32'h0, 32'h0);
            end
        end
        bound_ok(done, "drain_wait");
    endtask

    task automatic strobe(input bit b2b, input int nfix, input logic [31:0] t0,
                          input logic [31:0] t1);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            sync();
            if (exp_q.size() == 0 || (b2b && exp_q.size() == 1)) begin
                drive(1'b1, 1'b1, 1'b0, nfix, t0, t1);
                done = 1'b1;
            end else begin
                drive(1'b0, 1'b1, 1'b0, 0, 32'h0, 32'h0);
            end
        end
        bound_ok(done, "strobe_wait");
    endtask

    // Monitor: samples between the falling and rising edge, compares against the queue front.
    exp_t mon_e;
    bit   mon_v;
    always @(negedge clk) begin
        #3;
        mon_v = (exp_q.size() != 0);
        chk("valid16", 32'(h_valid), 32'(mon_v));
        chk("busy16", 32'(h_busy), 32'(mon_v));
        chk("valid32", 32'(w_valid), 32'(mon_v));
        chk("busy32", 32'(w_busy), 32'(mon_v));
        chk("drop16", 32'(h_drop), 32'(drop_now));
        chk("drop32", 32'(w_drop), 32'(drop_now));
        if (mon_v) begin
            mon_e = exp_q[0];
            chk("idx16", 32'(h_idx), 32'(mon_e.idx));
            chk("last16", 32'(h_last), 32'(mon_e.last));
            chk("data16", h_data, {16'h0, mon_e.d16});
            chk("idx32", 32'(w_idx), 32'(mon_e.idx));
            chk("last32", 32'(w_last), 32'(mon_e.last));
            chk("data32", w_data, mon_e.d32);
        end
        if (!rst_n) begin
            chk("rst_data16", h_data, 32'h0);
            chk("rst_idx16", 32'(h_idx), 32'h0);
            chk("rst_last16", 32'(h_last), 32'h0);
            chk("rst_data32", w_data, 32'h0);
            chk("rst_idx32", 32'(w_idx), 32'h0);
        end
        if (mon_v && out_ready && rst_n) void'(exp_q.pop_front());
        while (stage_q.size() != 0) exp_q.push_back(stage_q.pop_front());
        drop_now = drop_next;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [31:0] vecs [10];
    bit          r;
    bit          v;
    bit          c;
    bit          drop1;
    bit          drop2;
    bit          cleared;
    bit          found;

    initial begin
        errors       = 0;
        checks       = 0;
        drop_now     = 1'b0;
        drop_next    = 1'b0;
        rst_n        = 1'b0;
        result_valid = 1'b0;
        out_ready    = 1'b0;
        err_clear    = 1'b0;
        for (int i = 0; i < CE; i++) tile_in[i] = 32'h0;
        vecs = '{32'h3F801000, 32'h3F803000, 32'h477FE000, 32'h477FF000, 32'h33800000,
                 32'h33000000, 32'h33400000, 32'h7FC00000, 32'h80000000, 32'hFF800000};

        repeat (3) sync();
        sync();
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 0, 32'h0, 32'h0);
        idle(2, 1'b1);

        // First tile with full-rate drain.
        strobe(1'b0, 2, 32'h3F800000, 32'hC0000000);
        drain_all();
        idle(2, 1'b1);

        // Rounding vectors at idx0; the later ones arrive back-to-back.
        for (int i = 0; i < 10; i++) strobe(i >= 5, 1, vecs[i], 32'h0);
        drain_all();
        idle(2, 1'b1);

        // Backpressure 1,0,0,1 with drops, a lone clear, and clear racing a drop.
        strobe(1'b0, 0, 32'h0, 32'h0);
        drop1   = 1'b0;
        drop2   = 1'b0;
        cleared = 1'b0;
        for (int k = 0; k < 300 && (exp_q.size() != 0 || stage_q.size() != 0); k++) begin
            sync();
            r = (k % 4 == 0) || (k % 4 == 3);
            v = 1'b0;
            c = 1'b0;
            if (exp_q.size() != 0) begin
                if (!drop1 && exp_q[0].idx == 5 && !r) begin
                    v     = 1'b1;
                    drop1 = 1'b1;
                end else if (drop1 && !cleared && exp_q[0].idx >= 8) begin
                    c       = 1'b1;
                    cleared = 1'b1;
                end else if (cleared && !drop2 && exp_q[0].idx >= 11 && !r) begin
                    v     = 1'b1;
                    c     = 1'b1;
                    drop2 = 1'b1;
                end
            end
            drive(v, r, c, 0, 32'h0, 32'h0);
        end
        bound_ok(drop1 && drop2 && cleared, "bp_drop_sequence");
        idle(2, 1'b1);
        sync();
        drive(1'b0, 1'b1, 1'b1, 0, 32'h0, 32'h0);
        idle(2, 1'b1);

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            sync();
            drive(($urandom % 6) == 0, ($urandom % 3) != 0, ($urandom % 10) == 0,
                  0, 32'h0, 32'h0);
        end
        drain_all();
        sync();
        drive(1'b0, 1'b1, 1'b1, 0, 32'h0, 32'h0);
        idle(2, 1'b1);

        // Reset in the middle of a stream.
        strobe(1'b0, 1, 32'h3F801000, 32'h0);
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            sync();
            if (exp_q.size() != 0 && exp_q[0].idx == 7) begin
                found = 1'b1;
            end else begin
                drive(1'b0, 1'b1, 1'b0, 0, 32'h0, 32'h0);
            end
        end
        bound_ok(found, "reach_idx7");
        rst_n        = 1'b0;
        result_valid = 1'b0;
        err_clear    = 1'b0;
        out_ready    = 1'b1;
        exp_q.delete();
        stage_q.delete();
        drop_next = 1'b0;
        drop_now  = 1'b0;
        repeat (2) sync();
        sync();
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 0, 32'h0, 32'h0);
        idle(10, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
